// File: rtl/x7dn_sched.sv
// ============================================================================
// Module   : x7dn_sched
// Function : Sweeps a control word across the x7dn decode array and queues
//            each sampled result in a show-ahead FIFO. Optional macro
//            X7DN_SCHED_PARITY_EN adds the res_par output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module x7dn_sched #(
  parameter int DEPTH  = 4,
  parameter int MODE_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MODE_W-1:0] mode_base,
  input  logic [3:0]        mode_cnt,
  output logic [MODE_W-1:0] mode,
  input  logic [14:0]       res_in,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [14:0]       res_data
`ifdef X7DN_SCHED_PARITY_EN
  ,
  output logic              res_par
`endif
);

  localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_depth = c_cw'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_SAMPLE = 3'd2,
    S_PUSH   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t            r_state;
  logic [MODE_W-1:0] r_mode;
  logic [3:0]        r_step;
  logic [3:0]        r_cnt;
  logic [14:0]       r_hold;
  logic              r_busy;
  logic              r_done;

  logic [14:0]       r_mem [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_cw-1:0]   r_count;

  logic              w_push;
  logic              w_pop;
  logic              w_last;

  // Fullness is judged on the start-of-cycle count, so a same-cycle pop
  // never makes room for the push.
  assign w_push = (r_state == S_PUSH) && (r_count < c_depth);
  assign w_pop  = (r_count != '0) && res_ready;
  assign w_last = ({1'b0, r_step} + 5'd1) == {1'b0, r_cnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mode  <= '0;
      r_step  <= '0;
      r_cnt   <= '0;
      r_hold  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (mode_cnt != 4'd0) begin
              r_mode  <= mode_base;
              r_cnt   <= mode_cnt;
              r_step  <= '0;
              r_busy  <= 1'b1;
              r_state <= S_APPLY;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_APPLY: r_state <= S_SAMPLE;
        S_SAMPLE: begin
          r_hold  <= res_in;
          r_state <= S_PUSH;
        end
        S_PUSH: begin
          if (w_push) begin
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_step  <= r_step + 4'd1;
              r_mode  <= r_mode + {{(MODE_W-1){1'b0}}, 1'b1};
              r_state <= S_APPLY;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_hold;
  end

  assign mode      = r_mode;
  assign busy      = r_busy;
  assign done      = r_done;
  assign res_valid = (r_count != '0);
  // Empty FIFO presents zero so stale entries never leak out after reset.
  assign res_data  = res_valid ? r_mem[r_rd_ptr] : '0;

`ifdef X7DN_SCHED_PARITY_EN
  logic r_par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (w_push) r_par_mem[r_wr_ptr] <= ^r_hold;
  end

  assign res_par = res_valid ? r_par_mem[r_rd_ptr] : 1'b0;
`endif

endmodule

`default_nettype wire
